serial_paralelo_rx: RTL and testbench

Receive-side serial-to-parallel converter for the PHY. It takes the 1-bit serial line, hunts for the 8'hBC comma, and locks after BC_LOCK consecutive aligned commas. Once locked, it emits one byte per 8 bit times with a valid flag, and commas are stripped as idle filler. It sits directly upstream of the level-2 byte demux: its data_out and valid_out feed the demux Entrada and validEntrada.

---
 rtl/phy_pkg.sv | 13 +
 rtl/serial_paralelo_rx.sv | 130 +++++++++++++
 tb/tb_serial_paralelo_rx.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/phy_pkg.sv
// Shared PHY definitions: comma character, byte width and receiver alignment states.
package phy_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam logic [7:0]  COM_DEFAULT = 8'hBC;

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    ALIGN  = 2'b01,
    LOCKED = 2'b10
  } rx_state_e;

endpackage

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: hunts for the comma at bit granularity, locks after
// BC_LOCK aligned commas, then emits one byte per 8 bit times with commas stripped.
module serial_paralelo_rx
  import phy_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COM     = COM_DEFAULT,
  parameter int unsigned       BC_LOCK = 4
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              data_in,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic              active,
  output logic              byte_strobe
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned BC_W  = 4;
  localparam logic [BC_W-1:0] BC_LOCK_C = BC_W'(BC_LOCK);

  rx_state_e          state_q, state_d;
  logic [BYTE_W-2:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BC_W-1:0]    bc_q, bc_d;
  logic [BYTE_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               active_q, active_d;
  logic               strobe_q, strobe_d;

  logic [BYTE_W-1:0]  cand;
  logic               is_com;
  logic               byte_done;
  logic [BC_W-1:0]    bc_inc;

  assign cand      = {shreg_q, data_in};
  assign is_com    = (cand == COM);
  assign byte_done = (cnt_q == CNT_W'(7));
  assign bc_inc    = bc_q + BC_W'(1);

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q  <= HUNT;
      shreg_q  <= '0;
      cnt_q    <= '0;
      bc_q     <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      bc_q     <= bc_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      active_q <= active_d;
      strobe_q <= strobe_d;
    end
  end

  // Alignment FSM; valid/strobe/active are forced low outside LOCKED by the defaults.
  always_comb begin
    state_d  = state_q;
    shreg_d  = cand[BYTE_W-2:0];
    cnt_d    = cnt_q + CNT_W'(1);
    bc_d     = bc_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    active_d = 1'b0;
    strobe_d = 1'b0;

    case (state_q)
      HUNT: begin
        if (is_com) begin
          cnt_d = '0;
          bc_d  = BC_W'(1);
          if (BC_LOCK_C == BC_W'(1)) begin
            state_d  = LOCKED;
            active_d = 1'b1;
          end else begin
            state_d = ALIGN;
          end
        end
      end

      ALIGN: begin
        if (byte_done) begin
          if (is_com) begin
            bc_d = bc_inc;
            if (bc_inc == BC_LOCK_C) begin
              state_d  = LOCKED;
              active_d = 1'b1;
            end
          end else begin
            bc_d    = '0;
            state_d = HUNT;
          end
        end
      end

      LOCKED: begin
        active_d = 1'b1;
        valid_d  = valid_q;
        if (byte_done) begin
          strobe_d = 1'b1;
          if (is_com) begin
            valid_d = 1'b0;
          end else begin
            data_d  = cand;
            valid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = HUNT;
        bc_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign active      = active_q;
  assign byte_strobe = strobe_q;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Directed bench for serial_paralelo_rx: lock, offset, failed lock, idle stripping,
// false comma and asynchronous reset, with hand-computed expectations.
module tb_serial_paralelo_rx;

  logic       clk_32f;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       byte_strobe;

  int vectors;
  int miscompares;

  serial_paralelo_rx #(
    .COM    (8'hBC),
    .BC_LOCK(4)
  ) dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .active     (active),
    .byte_strobe(byte_strobe)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Drive one bit and return 1ns after the edge that sampled it.
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk_32f);
    @(posedge clk_32f);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [7:0] b;
    vectors     = 0;
    miscompares = 0;
    data_in     = 1'b0;
    reset       = 1'b0;
    #2;
    chk("rst_data", data_out, 8'h00);
    chk("rst_valid", 8'(valid_out), 8'h00);
    chk("rst_active", 8'(active), 8'h00);
    chk("rst_strobe", 8'(byte_strobe), 8'h00);
    @(posedge clk_32f);
    #1;
    reset = 1'b1;

    // Aligned lock: 4 commas then 0xAA, 0x55
    send_byte(8'hBC); send_byte(8'hBC); send_byte(8'hBC);
    chk("al_active_3bc", 8'(active), 8'h00);
    send_byte(8'hBC);
    chk("al_active_4bc", 8'(active), 8'h01);
    chk("al_valid_4bc", 8'(valid_out), 8'h00);
    chk("al_strobe_4bc", 8'(byte_strobe), 8'h00);
    send_byte(8'hAA);
    chk("al_data_aa", data_out, 8'hAA);
    chk("al_valid_aa", 8'(valid_out), 8'h01);
    chk("al_strobe_aa", 8'(byte_strobe), 8'h01);
    b = 8'h55;
    for (int i = 7; i >= 1; i--) begin
      send_bit(b[i]);
      chk("al_hold_data", data_out, 8'hAA);
      chk("al_hold_valid", 8'(valid_out), 8'h01);
      chk("al_hold_strobe", 8'(byte_strobe), 8'h00);
    end
    send_bit(b[0]);
    chk("al_data_55", data_out, 8'h55);
    chk("al_valid_55", 8'(valid_out), 8'h01);
    chk("al_strobe_55", 8'(byte_strobe), 8'h01);

    // Idle stripping: 0x01, comma, 0x02
    send_byte(8'h01);
    chk("idle_data_01", data_out, 8'h01);
    chk("idle_valid_01", 8'(valid_out), 8'h01);
    send_byte(8'hBC);
    chk("idle_data_bc", data_out, 8'h01);
    chk("idle_valid_bc", 8'(valid_out), 8'h00);
    chk("idle_strobe_bc", 8'(byte_strobe), 8'h01);
    send_byte(8'h02);
    chk("idle_data_02", data_out, 8'h02);
    chk("idle_valid_02", 8'(valid_out), 8'h01);

    // Reset mid-byte while locked and emitting 0xAA
    send_byte(8'hAA);
    chk("mr_data_aa", data_out, 8'hAA);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    #3;
    reset = 1'b0;
    #1;
    chk("mr_data", data_out, 8'h00);
    chk("mr_valid", 8'(valid_out), 8'h00);
    chk("mr_active", 8'(active), 8'h00);
    chk("mr_strobe", 8'(byte_strobe), 8'h00);
    @(posedge clk_32f);
    #1;
    reset = 1'b1;
    send_byte(8'hBC); send_byte(8'hBC); send_byte(8'hBC);
    chk("mr_active_3bc", 8'(active), 8'h00);
    send_byte(8'hBC);
    chk("mr_active_4bc", 8'(active), 8'h01);

    // Misaligned start: 3 stray bits, 4 commas, 0x3C
    do_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_byte(8'hBC); send_byte(8'hBC); send_byte(8'hBC);
    chk("mis_active_3bc", 8'(active), 8'h00);
    send_byte(8'hBC);
    chk("mis_active_4bc", 8'(active), 8'h01);
    b = 8'h3C;
    for (int i = 7; i >= 1; i--) send_bit(b[i]);
    chk("mis_valid_early", 8'(valid_out), 8'h00);
    send_bit(b[0]);
    chk("mis_data_3c", data_out, 8'h3C);
    chk("mis_valid_3c", 8'(valid_out), 8'h01);

    // Failed lock: 3 commas, 0x12, then 4 commas, 0x77
    do_reset();
    send_byte(8'hBC); send_byte(8'hBC); send_byte(8'hBC);
    send_byte(8'h12);
    chk("fl_active_12", 8'(active), 8'h00);
    chk("fl_valid_12", 8'(valid_out), 8'h00);
    chk("fl_data_12", data_out, 8'h00);
    send_byte(8'hBC); send_byte(8'hBC); send_byte(8'hBC);
    chk("fl_active_3bc", 8'(active), 8'h00);
    send_byte(8'hBC);
    chk("fl_active_4bc", 8'(active), 8'h01);
    send_byte(8'h77);
    chk("fl_data_77", data_out, 8'h77);
    chk("fl_valid_77", 8'(valid_out), 8'h01);

    // False comma across 0x5E|0x00 enters ALIGN; 3 more aligned commas reach lock
    do_reset();
    send_byte(8'h5E);
    send_bit(1'b0);
    send_byte(8'hBC); send_byte(8'hBC);
    chk("fcb_active_2bc", 8'(active), 8'h00);
    send_byte(8'hBC);
    chk("fcb_active_3bc", 8'(active), 8'h01);
    send_byte(8'hA5);
    chk("fcb_data_a5", data_out, 8'hA5);
    chk("fcb_valid_a5", 8'(valid_out), 8'h01);

    // False comma followed by 0x00 returns to HUNT; full 4-comma run needed
    do_reset();
    send_byte(8'h5E);
    send_bit(1'b0);
    send_byte(8'h00);
    chk("fca_active_00", 8'(active), 8'h00);
    chk("fca_valid_00", 8'(valid_out), 8'h00);
    send_byte(8'hBC); send_byte(8'hBC); send_byte(8'hBC);
    chk("fca_active_3bc", 8'(active), 8'h00);
    send_byte(8'hBC);
    chk("fca_active_4bc", 8'(active), 8'h01);
    send_byte(8'h77);
    chk("fca_data_77", data_out, 8'h77);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
